// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the raster command path: register offsets,
// opcodes, the packed command word layout and its width derivation.
package gpu_cmd_pkg;

  localparam int DEF_CHANNEL_BITS = 8;
  localparam int DEF_WIDTH_BITS   = 10;
  localparam int DEF_HEIGHT_BITS  = 9;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_P1     = 5'h04;
  localparam logic [4:0] ADDR_P2     = 5'h08;
  localparam logic [4:0] ADDR_COMMIT = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_PIXEL = 4'd1,
    OP_LINE  = 4'd2,
    OP_RECT  = 4'd3,
    OP_FILL  = 4'd4,
    OP_SWAP  = 4'd5
  } opcode_e;

  function automatic int cmd_width(input int channel_bits, input int width_bits,
                                   input int height_bits);
    return 4 + 3 * channel_bits + 2 * (width_bits + height_bits);
  endfunction

  localparam int DEF_CMD_W = cmd_width(DEF_CHANNEL_BITS, DEF_WIDTH_BITS, DEF_HEIGHT_BITS);

  // Field order matches the head-entry layout, MSB first.
  typedef struct packed {
    opcode_e                     opcode;
    logic [DEF_CHANNEL_BITS-1:0] r;
    logic [DEF_CHANNEL_BITS-1:0] g;
    logic [DEF_CHANNEL_BITS-1:0] b;
    logic [DEF_WIDTH_BITS-1:0]   x1;
    logic [DEF_HEIGHT_BITS-1:0]  y1;
    logic [DEF_WIDTH_BITS-1:0]   x2;
    logic [DEF_HEIGHT_BITS-1:0]  y2;
  } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo_if.sv
// APB slave bus plus the command stream towards the raster core.
interface apb_cmd_fifo_if #(
  parameter int CMD_W   = 66,
  parameter int COUNT_W = 4
);
  logic [31:0]        pAddr_i;
  logic [31:0]        pDataWrite_i;
  logic               pSel_i;
  logic               pEnable_i;
  logic               pWrite_i;
  logic [31:0]        pDataRead_o;
  logic [CMD_W-1:0]   cmd_o;
  logic               cmd_valid_o;
  logic               cmd_ready_i;
  logic               fifo_full_o;
  logic [COUNT_W-1:0] fifo_count_o;

  modport slave (
    input  pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i, cmd_ready_i,
    output pDataRead_o, cmd_o, cmd_valid_o, fifo_full_o, fifo_count_o
  );

  modport master (
    output pAddr_i, pDataWrite_i, pSel_i, pEnable_i, pWrite_i, cmd_ready_i,
    input  pDataRead_o, cmd_o, cmd_valid_o, fifo_full_o, fifo_count_o
  );
endinterface

// File: rtl/apb_cmd_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry always on dout, registered
// valid/full/count flags, push accepted when full if a pop coincides.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_next;
  logic               valid_q;
  logic               full_q;
  logic               pop_ok;
  logic               push_ok;

  assign pop_ok  = pop & valid_q;
  assign push_ok = push & (~full_q | pop_ok);

  always_comb begin
    count_next = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_q + COUNT_W'(1);
      2'b01:   count_next = count_q - COUNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_next;
      valid_q <= (count_next != '0);
      full_q  <= (count_next == COUNT_W'(DEPTH));
    end
  end

  // Storage needs no reset: the cleared count hides stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign valid = valid_q;
  assign full  = full_q;
  assign count = count_q;
endmodule

// File: rtl/apb_cmd_fifo.sv
// APB staging registers and COMMIT decode feeding a show-ahead command
// queue for the raster core; STATUS exposes queue state and overflow.
module apb_cmd_fifo
  import gpu_cmd_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CHANNEL_BITS = DEF_CHANNEL_BITS,
  parameter int WIDTH_BITS   = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS  = DEF_HEIGHT_BITS
) (
  input logic            clk,
  input logic            rst,
  apb_cmd_fifo_if.slave  bus
);
  localparam int CMD_W    = cmd_width(CHANNEL_BITS, WIDTH_BITS, HEIGHT_BITS);
  localparam int COLOUR_W = 3 * CHANNEL_BITS;
  localparam int COUNT_W  = $clog2(DEPTH) + 1;

  logic [3:0]             opcode_q;
  logic [COLOUR_W-1:0]    colour_q;
  logic [WIDTH_BITS-1:0]  x1_q;
  logic [HEIGHT_BITS-1:0] y1_q;
  logic [WIDTH_BITS-1:0]  x2_q;
  logic [HEIGHT_BITS-1:0] y2_q;
  logic                   overflow_q;

  logic [4:0]             addr;
  logic                   wr_en;
  logic                   commit;
  logic                   pop;
  logic                   drop;
  logic [CMD_W-1:0]       cmd_word;
  logic [CMD_W-1:0]       fifo_dout;
  logic                   fifo_valid;
  logic                   fifo_full;
  logic [COUNT_W-1:0]     fifo_count;
  logic [31:0]            rdata;
  logic                   unused_bits;

  assign addr   = bus.pAddr_i[4:0];
  assign wr_en  = bus.pSel_i & bus.pEnable_i & bus.pWrite_i;
  assign commit = wr_en && (addr == ADDR_COMMIT);
  assign pop    = fifo_valid & bus.cmd_ready_i;
  assign drop   = commit & fifo_full & ~pop;

  assign cmd_word = {opcode_q, colour_q, x1_q, y1_q, x2_q, y2_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q   <= '0;
      colour_q   <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x2_q       <= '0;
      y2_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_CTRL: begin
            opcode_q <= bus.pDataWrite_i[3:0];
            colour_q <= bus.pDataWrite_i[4 +: COLOUR_W];
          end
          ADDR_P1: begin
            x1_q <= bus.pDataWrite_i[0 +: WIDTH_BITS];
            y1_q <= bus.pDataWrite_i[16 +: HEIGHT_BITS];
          end
          ADDR_P2: begin
            x2_q <= bus.pDataWrite_i[0 +: WIDTH_BITS];
            y2_q <= bus.pDataWrite_i[16 +: HEIGHT_BITS];
          end
          ADDR_STATUS: if (bus.pDataWrite_i[2]) overflow_q <= 1'b0;
          default: ;
        endcase
      end
      // A dropped push in the same cycle as a clear leaves the flag set.
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.pSel_i && !bus.pWrite_i) begin
      case (addr)
        ADDR_CTRL: begin
          rdata[3:0]          = opcode_q;
          rdata[4 +: COLOUR_W] = colour_q;
        end
        ADDR_P1: begin
          rdata[0 +: WIDTH_BITS]   = x1_q;
          rdata[16 +: HEIGHT_BITS] = y1_q;
        end
        ADDR_P2: begin
          rdata[0 +: WIDTH_BITS]   = x2_q;
          rdata[16 +: HEIGHT_BITS] = y2_q;
        end
        ADDR_STATUS: begin
          rdata[0]            = ~fifo_valid;
          rdata[1]            = fifo_full;
          rdata[2]            = overflow_q;
          rdata[8 +: COUNT_W] = fifo_count;
        end
        default: rdata = '0;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit),
    .pop   (bus.cmd_ready_i),
    .din   (cmd_word),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign bus.pDataRead_o  = rdata;
  assign bus.cmd_o        = fifo_dout;
  assign bus.cmd_valid_o  = fifo_valid;
  assign bus.fifo_full_o  = fifo_full;
  assign bus.fifo_count_o = fifo_count;

  assign unused_bits = ^{bus.pAddr_i[31:5], bus.pDataWrite_i};
endmodule

// File: tb/tb_apb_cmd_fifo.sv
// Directed bench for apb_cmd_fifo: APB register access, push/pop ordering,
// overflow handling, wrap-around and mid-operation reset.
module tb_apb_cmd_fifo;
  import gpu_cmd_pkg::*;

  localparam int DEPTH   = 8;
  localparam int CMD_W   = cmd_width(8, 10, 9);
  localparam int COUNT_W = 4;

  logic tb_clk = 1'b0;
  logic tb_rst = 1'b1;
  always #5 tb_clk = ~tb_clk;

  apb_cmd_fifo_if #(.CMD_W(CMD_W), .COUNT_W(COUNT_W)) bus ();

  apb_cmd_fifo #(
    .DEPTH        (DEPTH),
    .CHANNEL_BITS (8),
    .WIDTH_BITS   (10),
    .HEIGHT_BITS  (9)
  ) dut (
    .clk (tb_clk),
    .rst (tb_rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [CMD_W-1:0] q[$];
  logic [31:0] st_ctrl, st_p1, st_p2;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] pack_exp(input logic [31:0] c, input logic [31:0] p1,
                                                 input logic [31:0] p2);
    cmd_t w;
    w.opcode = opcode_e'(c[3:0]);
    w.r  = c[27:20];
    w.g  = c[19:12];
    w.b  = c[11:4];
    w.x1 = p1[9:0];
    w.y1 = p1[24:16];
    w.x2 = p2[9:0];
    w.y2 = p2[24:16];
    return w;
  endfunction

  // rdy drives cmd_ready_i during the access phase only.
  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, input bit rdy);
    @(negedge tb_clk);
    bus.pSel_i = 1'b1; bus.pEnable_i = 1'b0; bus.pWrite_i = 1'b1;
    bus.pAddr_i = {27'd0, a}; bus.pDataWrite_i = d; bus.cmd_ready_i = 1'b0;
    @(negedge tb_clk);
    bus.pEnable_i = 1'b1; bus.cmd_ready_i = rdy;
    @(posedge tb_clk);
    case (a)
      ADDR_CTRL:   st_ctrl = d;
      ADDR_P1:     st_p1 = d;
      ADDR_P2:     st_p2 = d;
      ADDR_COMMIT: if (q.size() < DEPTH) q.push_back(pack_exp(st_ctrl, st_p1, st_p2));
      default: ;
    endcase
    @(negedge tb_clk);
    bus.pSel_i = 1'b0; bus.pEnable_i = 1'b0; bus.pWrite_i = 1'b0; bus.cmd_ready_i = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge tb_clk);
    bus.pSel_i = 1'b1; bus.pEnable_i = 1'b0; bus.pWrite_i = 1'b0; bus.pAddr_i = {27'd0, a};
    @(negedge tb_clk);
    bus.pEnable_i = 1'b1;
    #1 d = bus.pDataRead_o;
    @(negedge tb_clk);
    bus.pSel_i = 1'b0; bus.pEnable_i = 1'b0;
  endtask

  task automatic drain();
    @(negedge tb_clk);
    bus.cmd_ready_i = 1'b1;
    for (int k = 0; k < 40 && bus.cmd_valid_o; k++) @(negedge tb_clk);
    bus.cmd_ready_i = 1'b0;
    check("drain_valid", bus.cmd_valid_o, 1'b0);
    check("drain_count", bus.fifo_count_o, 0);
    check("drain_model_empty", q.size(), 0);
  endtask

  // Every pop the DUT performs must present the oldest pushed command.
  always @(negedge tb_clk) begin
    #2;
    if (chk_en && bus.cmd_valid_o === 1'b1 && bus.cmd_ready_i === 1'b1) begin
      if (q.size() == 0) check("pop_unexpected", 1, 0);
      else begin
        check("head_order", bus.cmd_o, q[0]);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    cmd_t c;
    bus.pAddr_i = '0; bus.pDataWrite_i = '0; bus.pSel_i = 1'b0;
    bus.pEnable_i = 1'b0; bus.pWrite_i = 1'b0; bus.cmd_ready_i = 1'b0;
    st_ctrl = '0; st_p1 = '0; st_p2 = '0;

    // 1. Reset
    repeat (2) @(negedge tb_clk);
    tb_rst = 1'b0;
    check("rst_valid", bus.cmd_valid_o, 1'b0);
    check("rst_count", bus.fifo_count_o, 0);
    check("rst_full", bus.fifo_full_o, 1'b0);
    apb_read(ADDR_STATUS, rd); check("rst_status", rd, 32'h0000_0001);
    apb_read(ADDR_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
    chk_en = 1'b1;

    // 2. Single command
    apb_write(ADDR_CTRL, 32'h0FF0_0002, 1'b0);
    apb_write(ADDR_P1, 32'h0020_0010, 1'b0);
    apb_write(ADDR_P2, 32'h0040_0030, 1'b0);
    apb_read(ADDR_CTRL, rd); check("ctrl_rb", rd, 32'h0FF0_0002);
    apb_read(ADDR_P1, rd);   check("p1_rb", rd, 32'h0020_0010);
    apb_read(ADDR_COMMIT, rd); check("commit_rd", rd, 32'h0);
    apb_write(ADDR_COMMIT, 32'h0, 1'b0);
    check("single_valid", bus.cmd_valid_o, 1'b1);
    check("single_count", bus.fifo_count_o, 1);
    c = bus.cmd_o;
    check("single_opcode", c.opcode, 4'd2);
    check("single_colour", {c.r, c.g, c.b}, 24'hFF0000);
    check("single_x1", c.x1, 16);
    check("single_y1", c.y1, 32);
    check("single_x2", c.x2, 48);
    check("single_y2", c.y2, 64);
    apb_read(ADDR_STATUS, rd); check("single_status", rd, 32'h0000_0100);
    @(negedge tb_clk); bus.cmd_ready_i = 1'b1;
    @(negedge tb_clk); bus.cmd_ready_i = 1'b0;
    check("single_popped", bus.cmd_valid_o, 1'b0);
    // Ready with nothing queued is ignored.
    @(negedge tb_clk); bus.cmd_ready_i = 1'b1;
    @(negedge tb_clk); bus.cmd_ready_i = 1'b0;
    check("idle_ready_count", bus.fifo_count_o, 0);

    // 3. Fill and overflow
    for (int i = 0; i < 9; i++) begin
      apb_write(ADDR_CTRL, 32'h00A0_0000 + i * 32'h0000_1010 + (i % 6), 1'b0);
      apb_write(ADDR_COMMIT, 32'h0, 1'b0);
      if (i == 7) begin
        check("fill_full", bus.fifo_full_o, 1'b1);
        check("fill_count", bus.fifo_count_o, 8);
      end
    end
    check("ovf_count", bus.fifo_count_o, 8);
    apb_read(ADDR_STATUS, rd); check("ovf_status", rd, 32'h0000_0806);
    apb_write(ADDR_STATUS, 32'h4, 1'b0);
    apb_read(ADDR_STATUS, rd); check("ovf_cleared", rd, 32'h0000_0802);

    // 4. Full with simultaneous pop and push
    apb_write(ADDR_CTRL, 32'h0123_4565, 1'b0);
    apb_write(ADDR_COMMIT, 32'h0, 1'b1);
    check("pp_count", bus.fifo_count_o, 8);
    check("pp_full", bus.fifo_full_o, 1'b1);
    apb_read(ADDR_STATUS, rd); check("pp_status", rd, 32'h0000_0802);
    drain();

    // 5. Wrap-around with random consumer stalls
    for (int i = 0; i < 20; i++) begin
      apb_write(ADDR_CTRL, 32'h0000_0100 * i + (i % 6), 1'($urandom_range(0, 1)));
      apb_write(ADDR_P2, 32'h0001_0003 * i, 1'($urandom_range(0, 1)));
      apb_write(ADDR_COMMIT, 32'h0, 1'($urandom_range(0, 1)));
    end
    drain();

    // 6. Reset mid-operation
    apb_write(ADDR_STATUS, 32'h4, 1'b0);
    for (int i = 0; i < 5; i++) apb_write(ADDR_COMMIT, 32'h0, 1'b0);
    check("mid_count5", bus.fifo_count_o, 5);
    apb_write(ADDR_P1, 32'h0005_0007, 1'b0);
    @(negedge tb_clk); tb_rst = 1'b1;
    @(negedge tb_clk); tb_rst = 1'b0;
    q.delete();
    st_ctrl = '0; st_p1 = '0; st_p2 = '0;
    check("mid_rst_count", bus.fifo_count_o, 0);
    check("mid_rst_valid", bus.cmd_valid_o, 1'b0);
    check("mid_rst_full", bus.fifo_full_o, 1'b0);
    apb_read(ADDR_CTRL, rd);   check("mid_rst_ctrl", rd, 32'h0);
    apb_read(ADDR_P1, rd);     check("mid_rst_p1", rd, 32'h0);
    apb_read(ADDR_P2, rd);     check("mid_rst_p2", rd, 32'h0);
    apb_read(ADDR_STATUS, rd); check("mid_rst_status", rd, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
